m_store_buffer: RTL
===================

// Module: m_store_buffer
// PURPOSE
//   Store-side companion of the load byte extender in the M stage. Accepts sw/sh/sb requests, computes
//   the 4-bit byte enable and lane-replicated write data, queues them in a small FIFO, and drains them
//   to the data-memory bus over a valid/ready handshake. Raises AdES on misaligned stores and flags
//   loads that hit a pending store so the hazard unit can stall them.
// PARAMETERS
//   DEPTH      2   FIFO entries; power of two, >= 2
//   PTR_W      1   log2(DEPTH); derived, not overridden
// PORTS
//   clk            in   1   clock, rising edge
//   reset          in   1   synchronous, active-high
//   req_valid      in   1   store request from M stage
//   req_ready      out  1   buffer can accept; = !full
//   req_op         in   2   `ST_NO / `ST_W / `ST_H / `ST_B
//   req_addr       in   32  byte address
//   req_data       in   32  rt value, unshifted
//   bus_valid      out  1   head entry valid; = !empty
//   bus_ready      in   1   memory accepts head this cycle
//   bus_addr       out  32  word address {addr[31:2],2'b00}
//   bus_byteen     out  4   byte enables of head entry
//   bus_wdata      out  32  lane-replicated data of head entry
//   ld_addr        in   32  address of load in M stage
//   ld_conflict    out  1   load word matches any valid entry (combinational)
//   buf_empty      out  1   no pending stores (for syscall/eret drain)
//   exc_ades       out  1   registered one-cycle AdES pulse
//   exc_badvaddr   out  32  faulting address, held until next exception
// BEHAVIOUR
//   Reset: count=0, rd/wr ptr=0, bus_valid=0, req_ready=1, buf_empty=1, exc_ades=0, exc_badvaddr=0.
//   Reset mid-operation drops all entries; no partial write reaches the bus after the reset edge.
//   Push: req_valid && req_ready && req_op!=`ST_NO && !misaligned -> entry written at wr_ptr.
//   Pop: bus_valid && bus_ready -> rd_ptr advances. Bus outputs come only from stored entries;
//     minimum latency request->bus_valid is 1 cycle, no combinational bypass.
//   Push+pop same cycle: count unchanged, both pointers advance. When full, req_ready=0 even if
//     bus_ready=1 that cycle (no pass-through).
//   Pointers wrap modulo DEPTH; count is PTR_W+1 bits, 0..DEPTH.
//   Alignment (A=req_addr[1:0]), captured at push:
//     ST_W: byteen=4'b1111, wdata=d
//     ST_H: byteen=4'b0011<<{A[1],1'b0}, wdata={2{d[15:0]}}
//     ST_B: byteen=4'b0001<<A, wdata={4{d[7:0]}}
//   Misaligned: ST_W with A!=0, ST_H with A[0]=1. Evaluated on req_valid regardless of req_ready;
//     entry not pushed; next cycle exc_ades=1 for exactly one cycle, exc_badvaddr=req_addr.
//   ld_conflict = OR over valid entries of (entry.addr[31:2]==ld_addr[31:2]); 0 when empty.
//   req_op=`ST_NO with req_valid: ignored, no push, no exception.
// CONFIGURATION
//   STORE_ADES_CHECK_EN defined: misalignment detection and exception as above.
//   Not defined: exc_ades tied 0, exc_badvaddr tied 0; low address bits ignored per op
//     (ST_W uses A=0, ST_H uses A[0]=0) and the store is pushed normally.
// STRUCTURE
//   defines.v gains `ST_NO=2'd0, `ST_W=2'd1, `ST_H=2'd2, `ST_B=2'd3 beside the existing `BE_* codes.
//   Sub-module m_store_align: combinational (op, A, d) -> (byteen, wdata, misaligned); instantiated
//     once on the request path. FIFO storage and control stay in m_store_buffer.
// TESTING
//   1. sb addr=0x13 d=0x000000AB, bus_ready=1 -> next cycle bus_addr=0x10 byteen=1000 wdata=0xABABABAB.
//   2. sh addr=0x22 d=0x1234 -> byteen=1100 wdata=0x12341234; sw addr=0x40 -> byteen=1111.
//   3. bus_ready=0, push 2 sw -> req_ready=0, count=2; third request not accepted; bus_ready=1 drains
//      in order, req_ready=1 the cycle after first pop.
//   4. Full, simultaneous push attempt and pop -> only pop occurs; half-full push+pop -> count stays 1.
//   5. sw addr=0x42 (EN defined) -> exc_ades pulse 1 cycle, exc_badvaddr=0x42, no push; EN undefined
//      -> push with bus_addr=0x40 byteen=1111.
//   6. Pending sw 0x100, ld_addr=0x102 -> ld_conflict=1; reset asserted -> bus_valid=0, buf_empty=1.

Source files
------------

// File: rtl/m_store_buffer_pkg.sv
// Shared types for the M-stage store buffer: store op codes, default depth and the FIFO entry layout.
package m_store_buffer_pkg;

  localparam int SB_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_NO = 2'd0,
    ST_W  = 2'd1,
    ST_H  = 2'd2,
    ST_B  = 2'd3
  } st_op_e;

  // Only the word address is kept; the byte enables carry the low address bits.
  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
  } sb_entry_t;

endpackage

// File: rtl/m_store_buffer_if.sv
// Request and data-memory bus bundle of the store buffer; the buffer is the slave side.
interface m_store_buffer_if;
  // Handshake: a beat transfers on a rising edge where valid && ready; the source holds
  // its payload stable while valid is high and ready low; ready never depends on valid.
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;

  modport master (
    output req_valid, req_op, req_addr, req_data, bus_ready,
    input  req_ready, bus_valid, bus_addr, bus_byteen, bus_wdata
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, bus_ready,
    output req_ready, bus_valid, bus_addr, bus_byteen, bus_wdata
  );
endinterface

// File: rtl/m_store_buffer_align.sv
// m_store_align: combinational byte-enable / lane replication for sw, sh, sb.
// STORE_ADES_CHECK_EN enables misalignment detection; otherwise low address bits are ignored per op.
module m_store_align
  import m_store_buffer_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] d,
  output logic [3:0]  byteen,
  output logic [31:0] wdata,
  output logic        misaligned
);

  always_comb begin
    byteen     = 4'b0000;
    wdata      = d;
    misaligned = 1'b0;
    case (op)
      ST_W: begin
        byteen = 4'b1111;
        wdata  = d;
`ifdef STORE_ADES_CHECK_EN
        misaligned = (a != 2'b00);
`endif
      end
      ST_H: begin
        // a[0] never selects a lane, so a disabled check simply drops it.
        byteen = a[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{d[15:0]}};
`ifdef STORE_ADES_CHECK_EN
        misaligned = a[0];
`endif
      end
      ST_B: begin
        byteen = 4'b0001 << a;
        wdata  = {4{d[7:0]}};
      end
      default: begin
        byteen = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/m_store_buffer.sv
// M-stage store buffer: aligns sw/sh/sb, queues them in a DEPTH-entry FIFO and drains to memory.
// STORE_ADES_CHECK_EN enables AdES on misaligned stores; otherwise exc_* are tied to zero.
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  m_store_buffer_if.slave   sb,
  input  logic [31:0]       ld_addr,
  output logic              ld_conflict,
  output logic              buf_empty,
  output logic              exc_ades,
  output logic [31:0]       exc_badvaddr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [3:0]  al_byteen;
  logic [31:0] al_wdata;
  logic        al_misaligned;

  m_store_align u_align (
    .op         (sb.req_op),
    .a          (sb.req_addr[1:0]),
    .d          (sb.req_data),
    .byteen     (al_byteen),
    .wdata      (al_wdata),
    .misaligned (al_misaligned)
  );

  sb_entry_t        entry_q [DEPTH];
  sb_entry_t        entry_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic full, empty, do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = sb.req_valid && !full && (sb.req_op != ST_NO) && !al_misaligned;
  assign do_pop  = !empty && sb.bus_ready;

  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      entry_d[wr_ptr_q] = '{waddr: sb.req_addr[31:2], byteen: al_byteen, wdata: al_wdata};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      entry_q  <= entry_d;
    end
  end

  // Bus sees only stored entries; a new request shows up one cycle after it is accepted.
  assign sb.req_ready  = !full;
  assign sb.bus_valid  = !empty;
  assign sb.bus_addr   = {entry_q[rd_ptr_q].waddr, 2'b00};
  assign sb.bus_byteen = entry_q[rd_ptr_q].byteen;
  assign sb.bus_wdata  = entry_q[rd_ptr_q].wdata;
  assign buf_empty     = empty;

  logic [PTR_W-1:0] slot_ofs;
  logic             ld_unused;
  assign ld_unused = ^ld_addr[1:0];

  // A slot is occupied when its distance from the read pointer is below the count.
  always_comb begin
    ld_conflict = 1'b0;
    slot_ofs    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_ofs = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, slot_ofs} < count_q) && (entry_q[i].waddr == ld_addr[31:2])) begin
        ld_conflict = 1'b1;
      end
    end
  end

`ifdef STORE_ADES_CHECK_EN
  logic        exc_ades_q, exc_ades_d;
  logic [31:0] exc_badvaddr_q, exc_badvaddr_d;

  always_comb begin
    exc_ades_d     = sb.req_valid && al_misaligned;
    exc_badvaddr_d = exc_ades_d ? sb.req_addr : exc_badvaddr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_ades_q     <= 1'b0;
      exc_badvaddr_q <= '0;
    end else begin
      exc_ades_q     <= exc_ades_d;
      exc_badvaddr_q <= exc_badvaddr_d;
    end
  end

  assign exc_ades     = exc_ades_q;
  assign exc_badvaddr = exc_badvaddr_q;
`else
  assign exc_ades     = 1'b0;
  assign exc_badvaddr = '0;
`endif

endmodule
